// File: rtl/rtio_time_pkg.sv
// Shared types for the RTIO timebase: FSM state and command opcode encodings.
package rtio_time_pkg;

  localparam int RTIO_COUNTER_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_PAUSED  = 2'd3
  } tc_state_t;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_START    = 3'd2,
    OP_PAUSE    = 3'd3,
    OP_RESUME   = 3'd4,
    OP_STOP     = 3'd5,
    OP_SET_STOP = 3'd6,
    OP_ILLEGAL  = 3'd7
  } tc_op_t;

endpackage

// File: rtl/rtio_time_controller.sv
// Master RTIO timebase: 64-bit time counter, auto_start pulse and command FSM.
// Optional stop-at-compare feature enabled by defining RTIO_TIME_STOP_AT_EN.
module rtio_time_controller
  import rtio_time_pkg::*;
#(
  parameter int COUNTER_WIDTH = RTIO_COUNTER_WIDTH,
  parameter int DELAY_WIDTH   = 16
) (
  input  logic                     rtio_clk,
  input  logic                     rtio_aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [COUNTER_WIDTH-1:0] cmd_data,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     auto_start,
  output logic                     running,
  output logic [1:0]               state,
  output logic                     wrapped,
  output logic                     cmd_error,
  output logic                     stop_hit
);

  tc_state_t                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [DELAY_WIDTH-1:0]   delay_q, delay_d;
  logic                     wrapped_q, wrapped_d;
  logic                     start_d, error_d, hit_d;
  logic [DELAY_WIDTH-1:0]   start_delay;
  tc_op_t                   op;
  logic                     stop_match;

  assign op          = (cmd_valid && cmd_ready) ? tc_op_t'(cmd_op) : OP_NOP;
  assign start_delay = cmd_data[DELAY_WIDTH-1:0];

`ifdef RTIO_TIME_STOP_AT_EN
  localparam bit STOP_AT_EN = 1'b1;
  logic [COUNTER_WIDTH-1:0] stop_q;

  assign stop_match = (state_q == ST_RUNNING) && (counter_q == stop_q);

  // Stop compare value starts at all-ones so an unconfigured run never halts early.
  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn)            stop_q <= '1;
    else if (op == OP_SET_STOP)   stop_q <= cmd_data;
  end
`else
  localparam bit STOP_AT_EN = 1'b0;
  assign stop_match = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    counter_d = counter_q;
    delay_d   = delay_q;
    wrapped_d = wrapped_q;
    start_d   = 1'b0;
    error_d   = 1'b0;
    hit_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        case (op)
          OP_NOP, OP_STOP: begin end
          OP_LOAD: begin
            counter_d = cmd_data;
            wrapped_d = 1'b0;
          end
          OP_START: begin
            if (start_delay == '0) begin
              state_d = ST_RUNNING;
              start_d = 1'b1;
            end else begin
              state_d = ST_ARMED;
              delay_d = start_delay;
            end
          end
          OP_SET_STOP: error_d = !STOP_AT_EN;
          default:     error_d = 1'b1;
        endcase
      end

      // Delay count d loaded on acceptance; the run starts on the edge that sees 1.
      ST_ARMED: begin
        delay_d = delay_q - 1'b1;
        if (op == OP_STOP) begin
          state_d = ST_IDLE;
        end else begin
          if (delay_q == DELAY_WIDTH'(1)) begin
            state_d = ST_RUNNING;
            start_d = 1'b1;
          end
          error_d = (op != OP_NOP) && !((op == OP_SET_STOP) && STOP_AT_EN);
        end
      end

      ST_RUNNING: begin
        if ((counter_q == '1) && !stop_match) wrapped_d = 1'b1;
        if (op == OP_STOP) begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end else if (stop_match) begin
          state_d = ST_IDLE;
          hit_d   = 1'b1;
        end else if (op == OP_PAUSE) begin
          state_d = ST_PAUSED;
        end else begin
          counter_d = counter_q + 1'b1;
        end
        case (op)
          OP_NOP, OP_PAUSE, OP_STOP: begin end
          OP_SET_STOP: error_d = !STOP_AT_EN;
          default:     error_d = 1'b1;
        endcase
      end

      ST_PAUSED: begin
        case (op)
          OP_NOP: begin end
          OP_RESUME: state_d = ST_RUNNING;
          OP_LOAD: begin
            counter_d = cmd_data;
            wrapped_d = 1'b0;
          end
          OP_STOP: begin
            state_d   = ST_IDLE;
            counter_d = '0;
          end
          OP_SET_STOP: error_d = !STOP_AT_EN;
          default:     error_d = 1'b1;
        endcase
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async reset; no pulse survives reset.
  always_ff @(posedge rtio_clk or negedge rtio_aresetn) begin
    if (!rtio_aresetn) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      delay_q    <= '0;
      wrapped_q  <= 1'b0;
      auto_start <= 1'b0;
      running    <= 1'b0;
      cmd_error  <= 1'b0;
      stop_hit   <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      delay_q    <= delay_d;
      wrapped_q  <= wrapped_d;
      auto_start <= start_d;
      running    <= (state_d == ST_RUNNING);
      cmd_error  <= error_d;
      stop_hit   <= hit_d;
      cmd_ready  <= 1'b1;
    end
  end

  assign state   = state_q;
  assign counter = counter_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_rtio_time_controller.sv
// Self-checking bench for rtio_time_controller: directed vector table, corner sequences, random vs model.
module tb_rtio_time_controller;
  import rtio_time_pkg::*;

  localparam int W = 64;
`ifdef RTIO_TIME_STOP_AT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic         rtio_clk = 1'b0;
  logic         rtio_aresetn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] counter;
  logic         auto_start, running, wrapped, cmd_error, stop_hit;
  logic [1:0]   state;

  rtio_time_controller dut (
    .rtio_clk    (rtio_clk),
    .rtio_aresetn(rtio_aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .counter     (counter),
    .auto_start  (auto_start),
    .running     (running),
    .state       (state),
    .wrapped     (wrapped),
    .cmd_error   (cmd_error),
    .stop_hit    (stop_hit)
  );

  always #5 rtio_clk = ~rtio_clk;

  typedef struct packed {
    logic [W-1:0] counter;
    logic [1:0]   state;
    logic         auto_start;
    logic         running;
    logic         wrapped;
    logic         cmd_error;
    logic         stop_hit;
    logic         cmd_ready;
  } obs_t;

  typedef struct {
    bit           v;
    logic [2:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] e_ctr;
    logic [1:0]   e_st;
    bit           e_as;
    bit           e_wr;
    bit           e_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic string fmt(obs_t o);
    return $sformatf("ctr=%h st=%0d as=%b run=%b wr=%b err=%b hit=%b rdy=%b",
                     o.counter, o.state, o.auto_start, o.running, o.wrapped,
                     o.cmd_error, o.stop_hit, o.cmd_ready);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.counter = counter;   o.state = state;         o.auto_start = auto_start;
    o.running = running;   o.wrapped = wrapped;     o.cmd_error = cmd_error;
    o.stop_hit = stop_hit; o.cmd_ready = cmd_ready;
    return o;
  endfunction

  function automatic obs_t mk_obs(logic [W-1:0] c, logic [1:0] st, bit as, bit wr,
                                  bit err, bit hit, bit rdy);
    obs_t o;
    o.counter = c; o.state = st; o.auto_start = as; o.running = (st == 2'd2);
    o.wrapped = wr; o.cmd_error = err; o.stop_hit = hit; o.cmd_ready = rdy;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic step(input bit v, input logic [2:0] op, input logic [W-1:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge rtio_clk);
    #1;
  endtask

  function automatic vec_t mk(bit v, logic [2:0] op, logic [W-1:0] d, logic [W-1:0] c,
                              logic [1:0] st, bit as, bit wr, bit err);
    vec_t t;
    t.v = v; t.op = op; t.d = d; t.e_ctr = c; t.e_st = st; t.e_as = as; t.e_wr = wr; t.e_err = err;
    return t;
  endfunction

  // Reference model: time is base + elapsed edges while running; the armed run begins at a fixed edge index.
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSED = 3;
  int           m_mode, m_e, m_t0, m_fire;
  logic [W-1:0] m_base, m_stop;
  bit           m_wr, m_as, m_err, m_hit, m_ready;

  task automatic model_reset();
    m_mode = M_IDLE; m_e = 0; m_t0 = 0; m_fire = 0; m_base = '0; m_stop = '1;
    m_wr = 0; m_as = 0; m_err = 0; m_hit = 0; m_ready = 0;
  endtask

  function automatic obs_t model_obs();
    logic [W-1:0] c;
    c = (m_mode == M_RUN) ? m_base + 64'(m_e - m_t0) : m_base;
    return mk_obs(c, 2'(m_mode), m_as, m_wr, m_err, m_hit, m_ready);
  endfunction

  function automatic bit op_legal(int mode, logic [2:0] op);
    case (op)
      OP_NOP, OP_STOP: return 1'b1;
      OP_LOAD:         return (mode == M_IDLE) || (mode == M_PAUSED);
      OP_START:        return mode == M_IDLE;
      OP_PAUSE:        return mode == M_RUN;
      OP_RESUME:       return mode == M_PAUSED;
      OP_SET_STOP:     return STOP_EN;
      default:         return 1'b0;
    endcase
  endfunction

  task automatic model_edge(input bit v, input logic [2:0] op_in, input logic [W-1:0] d);
    logic [W-1:0] cur;
    logic [2:0]   op;
    bit           match;
    cur   = model_obs().counter;
    op    = (v && m_ready) ? op_in : 3'd0;
    m_e++;
    m_ready = 1'b1;
    m_err = !op_legal(m_mode, op);
    m_as  = 0;
    m_hit = 0;
    match = STOP_EN && (m_mode == M_RUN) && (cur == m_stop);
    if ((m_mode == M_RUN) && (cur == '1) && !match) m_wr = 1;
    if ((op == OP_SET_STOP) && STOP_EN) m_stop = d;
    case (m_mode)
      M_IDLE: begin
        if (op == OP_LOAD) begin m_base = d; m_wr = 0; end
        else if (op == OP_START) begin
          if (d[15:0] == 16'd0) begin m_mode = M_RUN; m_t0 = m_e; m_as = 1; end
          else begin m_mode = M_ARMED; m_fire = m_e + int'(d[15:0]); end
        end
      end
      M_ARMED: begin
        if (op == OP_STOP) m_mode = M_IDLE;
        else if (m_e == m_fire) begin m_mode = M_RUN; m_t0 = m_e; m_as = 1; end
      end
      M_RUN: begin
        if (op == OP_STOP)       begin m_mode = M_IDLE;   m_base = '0; end
        else if (match)          begin m_mode = M_IDLE;   m_base = cur; m_hit = 1; end
        else if (op == OP_PAUSE) begin m_mode = M_PAUSED; m_base = cur; end
      end
      default: begin
        if (op == OP_RESUME)    begin m_mode = M_RUN; m_t0 = m_e; end
        else if (op == OP_LOAD) begin m_base = d; m_wr = 0; end
        else if (op == OP_STOP) begin m_mode = M_IDLE; m_base = '0; end
      end
    endcase
  endtask

  vec_t tbl[$];

  initial begin
    localparam logic [W-1:0] NEAR_TOP = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [W-1:0] TOP      = 64'hFFFF_FFFF_FFFF_FFFF;

    // Directed vectors; each row is one cycle: drive, clock, expect.
    tbl.push_back(mk(1, OP_SET_STOP, 64'h200, 64'h0,   2'd0, 0, 0, !STOP_EN));
    tbl.push_back(mk(1, OP_LOAD,   64'h100, 64'h100, 2'd0, 0, 0, 0));
    tbl.push_back(mk(1, OP_START,  64'h3,   64'h100, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h100, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h100, 2'd1, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h100, 2'd2, 1, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h101, 2'd2, 0, 0, 0));
    tbl.push_back(mk(1, OP_LOAD,   64'h7,   64'h102, 2'd2, 0, 0, 1));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h103, 2'd2, 0, 0, 0));
    tbl.push_back(mk(1, OP_PAUSE,  64'h0,   64'h103, 2'd3, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h103, 2'd3, 0, 0, 0));
    tbl.push_back(mk(1, OP_RESUME, 64'h0,   64'h103, 2'd2, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h104, 2'd2, 0, 0, 0));
    tbl.push_back(mk(1, OP_STOP,   64'h0,   64'h0,   2'd0, 0, 0, 0));
    tbl.push_back(mk(1, OP_ILLEGAL,64'h0,   64'h0,   2'd0, 0, 0, 1));
    tbl.push_back(mk(1, OP_RESUME, 64'h0,   64'h0,   2'd0, 0, 0, 1));
    tbl.push_back(mk(1, OP_LOAD,   NEAR_TOP, NEAR_TOP, 2'd0, 0, 0, 0));
    tbl.push_back(mk(1, OP_START,  64'h0,   NEAR_TOP, 2'd2, 1, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   TOP,     2'd2, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h0,   2'd2, 0, 1, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h1,   2'd2, 0, 1, 0));
    tbl.push_back(mk(1, OP_PAUSE,  64'h0,   64'h1,   2'd3, 0, 1, 0));
    tbl.push_back(mk(1, OP_LOAD,   64'h55,  64'h55,  2'd3, 0, 0, 0));
    tbl.push_back(mk(1, OP_STOP,   64'h0,   64'h0,   2'd0, 0, 0, 0));
    tbl.push_back(mk(1, OP_START,  64'h1,   64'h0,   2'd1, 0, 0, 0));
    tbl.push_back(mk(1, OP_PAUSE,  64'h0,   64'h0,   2'd2, 1, 0, 1));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h1,   2'd2, 0, 0, 0));
    tbl.push_back(mk(1, OP_STOP,   64'h0,   64'h0,   2'd0, 0, 0, 0));
    tbl.push_back(mk(1, OP_START,  64'h2,   64'h0,   2'd1, 0, 0, 0));
    tbl.push_back(mk(1, OP_STOP,   64'h0,   64'h0,   2'd0, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h0,   2'd0, 0, 0, 0));
    tbl.push_back(mk(0, OP_NOP,    64'h0,   64'h0,   2'd0, 0, 0, 0));

    // Reset values, then a command offered on the release edge must be ignored.
    @(posedge rtio_clk);
    #1;
    check("reset_values", sample(), mk_obs('0, 2'd0, 0, 0, 0, 0, 0));
    #2 rtio_aresetn = 1'b1;
    step(1, OP_LOAD, 64'hABC);
    check("first_edge_ready", sample(), mk_obs('0, 2'd0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].op, tbl[i].d);
      check($sformatf("vec[%0d]", i), sample(),
            mk_obs(tbl[i].e_ctr, tbl[i].e_st, tbl[i].e_as, tbl[i].e_wr, tbl[i].e_err, 0, 1));
    end

`ifdef RTIO_TIME_STOP_AT_EN
    step(1, OP_SET_STOP, 64'h200);
    step(1, OP_LOAD, 64'h1F0);
    step(1, OP_START, 64'h0);
    check("stop_run_start", sample(), mk_obs(64'h1F0, 2'd2, 1, 0, 0, 0, 1));
    for (int i = 0; i < 16; i++) step(0, OP_NOP, '0);
    check("stop_at_match", sample(), mk_obs(64'h200, 2'd2, 0, 0, 0, 0, 1));
    step(0, OP_NOP, '0);
    check("stop_hit_pulse", sample(), mk_obs(64'h200, 2'd0, 0, 0, 0, 1, 1));
    step(0, OP_NOP, '0);
    check("stop_hit_clear", sample(), mk_obs(64'h200, 2'd0, 0, 0, 0, 0, 1));
`endif

    // Reset asserted mid-run takes effect without a clock edge.
    step(1, OP_LOAD, 64'h5000);
    step(1, OP_START, 64'h0);
    check("pre_reset_run", sample(), mk_obs(64'h5000, 2'd2, 1, 0, 0, 0, 1));
    #2 rtio_aresetn = 1'b0;
    #1;
    check("async_reset", sample(), mk_obs('0, 2'd0, 0, 0, 0, 0, 0));
    step(0, OP_NOP, '0);
    check("reset_held", sample(), mk_obs('0, 2'd0, 0, 0, 0, 0, 0));
    #2 rtio_aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, OP_NOP, '0);
      check($sformatf("post_release[%0d]", i), sample(), mk_obs('0, 2'd0, 0, 0, 0, 0, 1));
    end

    // Random command stream against the model, starting from a fresh reset.
    #2 rtio_aresetn = 1'b0;
    #3;
    model_reset();
    rtio_aresetn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit           v;
      logic [2:0]   op;
      logic [W-1:0] d;
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      if (op == OP_START)    d[15:0] = 16'($urandom_range(0, 4));
      if (op == OP_SET_STOP) d = model_obs().counter + 64'($urandom_range(0, 12));
      step(v, op, d);
      model_edge(v, op, d);
      check($sformatf("rand[%0d]", i), sample(), model_obs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
